mac_job_arbiter: RTL and testbench
==================================

MAC_JOB_ARBITER -- requirements
Module: mac_job_arbiter

Interface
REQ-001 Parameters: param_M 4, rows of A/C; param_K 4, inner dimension; param_N 4, columns of B/C; DATA_WIDTH_INITIAL 8, A/B element width; DATA_WIDTH_FINAL DATA_WIDTH_INITIAL*2, C element width; TIMEOUT 1024, maximum WAIT_DONE cycles.
REQ-002 clk  in  1  single clock; all logic is rising-edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 req_val  in  2  per-requester job valid.
REQ-005 req_rdy  out  2  per-requester job accept.
REQ-006 req_a  in  2 x (M*K) x DATA_WIDTH_INITIAL  per-requester matrix A.
REQ-007 req_b  in  2 x (K*N) x DATA_WIDTH_INITIAL  per-requester matrix B, pre-transposed.
REQ-008 rsp_val  out  2  per-requester result valid.
REQ-009 rsp_rdy  in  2  per-requester result accept.
REQ-010 rsp_c  out  (M*N) x DATA_WIDTH_FINAL  result matrix, shared by both requesters.
REQ-011 rsp_err  out  1  result is a timeout; qualified by rsp_val.
REQ-012 busy  out  1  state is not IDLE.
REQ-013 err_sticky  out  1  a timeout has occurred since reset.
REQ-014 mac_h2b_val  out  1  drives mac_top host2block_val.
REQ-015 mac_h2b_rdy  in  1  from mac_top host2block_rdy.
REQ-016 mac_a / mac_b / mac_we  out  A width / B width / 1  drive a_data_in_ext / b_data_in_ext / a_b_we_ext.
REQ-017 mac_b2h_rdy / mac_c_re  out  1 / 1  drive block2host_rdy / c_re_ext.
REQ-018 mac_c / mac_done / mac_b2h_val  in  C width / 1 / 1  from c_data_out_ext / mac_done / block2host_val.

Function
REQ-019 FSM states SHALL be IDLE, REQ, LOAD, WAIT_DONE, DRAIN, READ, RESP.
REQ-020 IDLE: req_rdy SHALL be one-hot to the round-robin winner among asserted req_val, else zero.
REQ-021 Accept (req_val&req_rdy) SHALL latch req_a/req_b and the grant id, then go to REQ.
REQ-022 Round-robin: after a grant, the other requester SHALL win the next contention; after reset, requester 0 wins.
REQ-023 REQ: mac_h2b_val=1; go to LOAD on the cycle after mac_h2b_rdy is sampled high.
REQ-024 LOAD: exactly one cycle with mac_h2b_val=1, mac_we=1, mac_a/mac_b=latched data; then WAIT_DONE.
REQ-025 Outside LOAD, mac_a, mac_b and mac_we SHALL be zero.
REQ-026 WAIT_DONE: an up-counter SHALL run from 0; mac_done=1 goes to DRAIN.
REQ-027 WAIT_DONE: if the count reaches TIMEOUT-1 with mac_done=0, zero the result register, set err_sticky and the error flag, and go to RESP.
REQ-028 DRAIN: one idle cycle, then READ.
REQ-029 READ: exactly one cycle with mac_b2h_rdy=1 and mac_c_re=1; mac_c SHALL be captured into the result register at the end of that cycle; then RESP.
REQ-030 RESP: rsp_val SHALL be asserted only for the granted id; rsp_c and rsp_err SHALL be held stable until rsp_rdy of that id is high, then go to IDLE.
REQ-031 A req_val from the non-granted requester while busy SHALL be ignored (req_rdy=0) and held pending; no job is dropped.
REQ-032 Both req_val rising in the same IDLE cycle: only the round-robin winner is accepted; the loser is accepted on the first IDLE after its winner's RESP.
REQ-033 mac_done or mac_b2h_val outside WAIT_DONE or READ SHALL be ignored.
REQ-034 Accept-to-rsp_val latency SHALL be 1 + REQ wait + 1 + WAIT_DONE length + 1 + 1 cycles.

Reset
REQ-035 rstn low SHALL asynchronously force: state IDLE; all outputs 0; counter, result register, grant id and err_sticky cleared; round-robin favours requester 0.
REQ-036 Reset mid-job SHALL abandon the job with no rsp_val issued.

Structure
REQ-037 Package mac_pkg SHALL hold the FSM state enum, the matrix and element width localparams, and the requester-id typedef.
REQ-038 A single sub-module rr_arb2 SHALL implement the 2-way round-robin grant and priority pointer.

Verification
REQ-039 Single job, M=K=N=4, A[i]=i, B[i]=i transposed, from requester 0 -> rsp_val[0] only, rsp_c[0]=56, rsp_err=0.
REQ-040 Both req_val high in the same cycle after reset -> requester 0 served, then requester 1; req_rdy is never 2'b11.
REQ-041 Back-to-back jobs from requester 1 while requester 0 is pending -> grants alternate 1,0,1.
REQ-042 mac_done never asserted -> rsp_val after exactly TIMEOUT WAIT_DONE cycles; rsp_err=1, rsp_c=0, err_sticky=1.
REQ-043 rsp_rdy held low for 20 cycles -> rsp_c stable and no new req_rdy until acceptance.
REQ-044 rstn pulsed low during WAIT_DONE -> all outputs 0 immediately; no rsp_val afterwards; next job completes normally.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared sizing, FSM state encoding and requester-id type for the MAC job arbiter.
package mac_pkg;

  localparam int MAT_M          = 4;
  localparam int MAT_K          = 4;
  localparam int MAT_N          = 4;
  localparam int DW_IN          = 8;
  localparam int DW_OUT         = DW_IN * 2;
  localparam int TIMEOUT_CYCLES = 1024;

  typedef logic req_id_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    WAIT_DONE,
    DRAIN,
    READ,
    RESP
  } arb_state_t;

  function automatic logic [1:0] id_to_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips away from whoever was just served.
module rr_arb2
  import mac_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  req_id_t prio;

  always_comb begin
    grant    = 2'b00;
    grant_id = prio;
    case (req)
      2'b01: begin
        grant    = 2'b01;
        grant_id = 1'b0;
      end
      2'b10: begin
        grant    = 2'b10;
        grant_id = 1'b1;
      end
      2'b11: begin
        grant    = id_to_onehot(prio);
        grant_id = prio;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio <= 1'b0;
    end else if (advance) begin
      prio <= ~grant_id;
    end
  end

endmodule

// File: rtl/mac_job_arbiter.sv
// Shares one MAC block between two requesters: accepts a job, loads it, waits for
// completion (with timeout), reads the result back and hands it to the owner.
module mac_job_arbiter
  import mac_pkg::*;
#(
  parameter  int param_M            = MAT_M,
  parameter  int param_K            = MAT_K,
  parameter  int param_N            = MAT_N,
  parameter  int DATA_WIDTH_INITIAL = DW_IN,
  parameter  int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2,
  parameter  int TIMEOUT            = TIMEOUT_CYCLES,
  localparam int A_W   = param_M * param_K * DATA_WIDTH_INITIAL,
  localparam int B_W   = param_K * param_N * DATA_WIDTH_INITIAL,
  localparam int C_W   = param_M * param_N * DATA_WIDTH_FINAL,
  localparam int CNT_W = $clog2(TIMEOUT)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          req_val,
  output logic [1:0]          req_rdy,
  input  logic [1:0][A_W-1:0] req_a,
  input  logic [1:0][B_W-1:0] req_b,
  output logic [1:0]          rsp_val,
  input  logic [1:0]          rsp_rdy,
  output logic [C_W-1:0]      rsp_c,
  output logic                rsp_err,
  output logic                busy,
  output logic                err_sticky,
  output logic                mac_h2b_val,
  input  logic                mac_h2b_rdy,
  output logic [A_W-1:0]      mac_a,
  output logic [B_W-1:0]      mac_b,
  output logic                mac_we,
  output logic                mac_b2h_rdy,
  output logic                mac_c_re,
  input  logic [C_W-1:0]      mac_c,
  input  logic                mac_done,
  input  logic                mac_b2h_val
);

  arb_state_t       state;
  logic [A_W-1:0]   a_lat;
  logic [B_W-1:0]   b_lat;
  logic [C_W-1:0]   result;
  logic             err_flag;
  req_id_t          gnt_id;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       grant;
  req_id_t          win_id;
  logic             accept;

  // block2host_val carries no extra information: C is readable once mac_done has fired.
  logic unused_b2h_val;
  assign unused_b2h_val = mac_b2h_val;

  rr_arb2 u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req_val),
    .advance (accept),
    .grant   (grant),
    .grant_id(win_id)
  );

  assign req_rdy = (state == IDLE && rstn) ? grant : 2'b00;
  assign accept  = |(req_val & req_rdy);

  assign busy        = (state != IDLE);
  assign mac_h2b_val = (state == REQ) || (state == LOAD);
  assign mac_we      = (state == LOAD);
  assign mac_a       = (state == LOAD) ? a_lat : '0;
  assign mac_b       = (state == LOAD) ? b_lat : '0;
  assign mac_b2h_rdy = (state == READ);
  assign mac_c_re    = (state == READ);
  assign rsp_val     = (state == RESP) ? id_to_onehot(gnt_id) : 2'b00;
  assign rsp_c       = result;
  assign rsp_err     = err_flag;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      a_lat      <= '0;
      b_lat      <= '0;
      result     <= '0;
      err_flag   <= 1'b0;
      err_sticky <= 1'b0;
      gnt_id     <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_lat    <= req_a[win_id];
            b_lat    <= req_b[win_id];
            gnt_id   <= win_id;
            err_flag <= 1'b0;
            state    <= REQ;
          end
        end
        REQ: begin
          if (mac_h2b_rdy) state <= LOAD;
        end
        LOAD: begin
          wait_cnt <= '0;
          state    <= WAIT_DONE;
        end
        // A hung MAC still produces a response, flagged as an error with an all-zero C.
        WAIT_DONE: begin
          if (mac_done) begin
            state <= DRAIN;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            result     <= '0;
            err_flag   <= 1'b1;
            err_sticky <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DRAIN: state <= READ;
        READ: begin
          result <= mac_c;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_rdy[gnt_id]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Directed bench for mac_job_arbiter: a behavioural MAC stub plus a table of jobs
// and hand-written sequences for contention, timeout and mid-job reset.
module tb_mac_job_arbiter;
  import mac_pkg::*;

  localparam int M   = 4;
  localparam int K   = 4;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int DWF = 16;
  localparam int TMO = 1024;
  localparam int AW  = M * K * DW;
  localparam int BW  = K * N * DW;
  localparam int CW  = M * N * DWF;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic [1:0]          req_val = 2'b00;
  logic [1:0]          req_rdy;
  logic [1:0][AW-1:0]  req_a = '0;
  logic [1:0][BW-1:0]  req_b = '0;
  logic [1:0]          rsp_val;
  logic [1:0]          rsp_rdy = 2'b00;
  logic [CW-1:0]       rsp_c;
  logic                rsp_err, busy, err_sticky;
  logic                mac_h2b_val;
  logic                mac_h2b_rdy = 1'b0;
  logic [AW-1:0]       mac_a;
  logic [BW-1:0]       mac_b;
  logic                mac_we, mac_b2h_rdy, mac_c_re;
  logic [CW-1:0]       mac_c = '0;
  logic                mac_done;
  logic                mac_b2h_val = 1'b1;
  logic                stub_done = 1'b0;
  logic                noise_done = 1'b0;

  assign mac_done = stub_done | noise_done;

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_sticky = 1'b0;

  typedef struct {
    int         id;
    int         mode;
    int         h2b_wait;
    int         done_delay;
    int         hold;
    logic [1:0] raise_acc;
    logic [1:0] raise_rel;
    int         exp_lat;
    logic       exp_err;
    int         exp_c0;
  } job_t;

  job_t tbl[4];

  mac_job_arbiter dut (
    .clk(clk), .rstn(rstn), .req_val(req_val), .req_rdy(req_rdy),
    .req_a(req_a), .req_b(req_b), .rsp_val(rsp_val), .rsp_rdy(rsp_rdy),
    .rsp_c(rsp_c), .rsp_err(rsp_err), .busy(busy), .err_sticky(err_sticky),
    .mac_h2b_val(mac_h2b_val), .mac_h2b_rdy(mac_h2b_rdy), .mac_a(mac_a),
    .mac_b(mac_b), .mac_we(mac_we), .mac_b2h_rdy(mac_b2h_rdy), .mac_c_re(mac_c_re),
    .mac_c(mac_c), .mac_done(mac_done), .mac_b2h_val(mac_b2h_val)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] matmul(input logic [AW-1:0] a, input logic [BW-1:0] b);
    logic [CW-1:0]  c;
    logic [DWF-1:0] acc;
    c = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int k = 0; k < K; k++)
          acc += DWF'(a[(i*K+k)*DW +: DW]) * DWF'(b[(j*K+k)*DW +: DW]);
        c[(i*N+j)*DWF +: DWF] = acc;
      end
    end
    return c;
  endfunction

  function automatic logic [AW-1:0] gen_a(input int mode);
    logic [AW-1:0] v;
    v = '0;
    for (int i = 0; i < M*K; i++)
      v[i*DW +: DW] = (mode == 0) ? DW'(i) : DW'(i*mode + 1);
    return v;
  endfunction

  // Mode 0 is B[k][j] = k*N+j stored transposed; other modes are a plain ramp.
  function automatic logic [BW-1:0] gen_b(input int mode);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++)
      for (int k = 0; k < K; k++)
        v[(j*K+k)*DW +: DW] = (mode == 0) ? DW'(k*N + j) : DW'((j*K+k)*mode + 3);
    return v;
  endfunction

  // MAC stub: h2b_rdy after h2b_wait REQ cycles, mac_done on WAIT cycle done_delay (0 = never).
  int   h2b_wait = 0;
  int   done_delay = 3;
  int   req_cnt = 0;
  int   stub_cnt = 0;
  logic in_wait = 1'b0;

  always @(negedge clk) begin
    stub_done = 1'b0;
    if (!rstn) begin
      in_wait     = 1'b0;
      req_cnt     = 0;
      mac_h2b_rdy = 1'b0;
    end else begin
      if (mac_h2b_val && !mac_we) begin
        mac_h2b_rdy = (req_cnt >= h2b_wait);
        req_cnt++;
      end else begin
        mac_h2b_rdy = 1'b0;
        req_cnt     = 0;
      end
      if (mac_we) begin
        mac_c    = matmul(mac_a, mac_b);
        in_wait  = 1'b1;
        stub_cnt = 0;
      end else if (in_wait) begin
        stub_cnt++;
        if (rsp_val != 2'b00) begin
          in_wait = 1'b0;
        end else if (done_delay > 0 && stub_cnt == done_delay) begin
          stub_done = 1'b1;
          in_wait   = 1'b0;
        end
      end
    end
  end

  int grant_log[$];
  int both_rdy = 0;
  int leak = 0;

  always @(posedge clk)
    if (rstn && (req_val & req_rdy) != 2'b00) grant_log.push_back(req_rdy[1] ? 1 : 0);

  always @(negedge clk) begin
    if (req_rdy == 2'b11) both_rdy++;
    if (!mac_we && (mac_a != '0 || mac_b != '0)) leak++;
  end

  task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one job end to end; call it at a negedge, it returns at a negedge.
  task automatic applyStimulus(input job_t j);
    int            cyc;
    logic [1:0]    onehot;
    logic [CW-1:0] held_c;
    logic [CW-1:0] exp_c;
    bit            stable;
    onehot     = (j.id != 0) ? 2'b10 : 2'b01;
    h2b_wait   = j.h2b_wait;
    done_delay = j.done_delay;
    req_a[j.id]   = gen_a(j.mode);
    req_b[j.id]   = gen_b(j.mode);
    req_val[j.id] = 1'b1;
    #1;
    cyc = 0;
    while (!req_rdy[j.id] && cyc < 2000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checkOutput("req_rdy grant", CW'(req_rdy), CW'(onehot));
    @(posedge clk);
    #1;
    req_val[j.id] = 1'b0;
    req_val = req_val | j.raise_acc;
    cyc = 1;
    @(negedge clk);
    while (rsp_val == 2'b00 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (j.exp_err) exp_sticky = 1'b1;
    exp_c = j.exp_err ? '0 : matmul(gen_a(j.mode), gen_b(j.mode));
    checkOutput("latency", CW'(cyc), CW'(j.exp_lat));
    checkOutput("rsp_val owner", CW'(rsp_val), CW'(onehot));
    checkOutput("rsp_err", CW'(rsp_err), CW'(j.exp_err));
    checkOutput("rsp_c matrix", rsp_c, exp_c);
    checkOutput("rsp_c[0]", CW'(rsp_c[DWF-1:0]), CW'(j.exp_c0));
    checkOutput("err_sticky", CW'(err_sticky), CW'(exp_sticky));
    held_c = rsp_c;
    stable = 1'b1;
    for (int h = 0; h < j.hold; h++) begin
      @(negedge clk);
      if (rsp_c !== held_c || rsp_val !== onehot || rsp_err !== j.exp_err || req_rdy !== 2'b00)
        stable = 1'b0;
    end
    if (j.hold > 0) checkOutput("hold stable", CW'(stable), CW'(1));
    rsp_rdy[j.id] = 1'b1;
    @(posedge clk);
    #1;
    rsp_rdy = 2'b00;
    req_val = req_val | j.raise_rel;
    @(negedge clk);
    checkOutput("idle after resp", CW'({busy, rsp_val}), CW'(0));
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   quiet;
    job_t j;

    //             id mode w  d   hold raise_acc raise_rel lat  err c0
    tbl[0] = '{0, 0, 0, 3, 0,  2'b00, 2'b00, 8,    1'b0, 56};
    tbl[1] = '{1, 1, 2, 5, 4,  2'b00, 2'b00, 12,   1'b0, 50};
    tbl[2] = '{0, 2, 1, 1, 0,  2'b00, 2'b00, 7,    1'b0, 116};
    tbl[3] = '{1, 1, 0, 0, 20, 2'b01, 2'b00, 1027, 1'b1, 0};

    // Reset state, with both requests asserted to show req_rdy is held off.
    req_val = 2'b11;
    repeat (3) @(negedge clk);
    checkOutput("reset req_rdy", CW'(req_rdy), CW'(0));
    checkOutput("reset busy", CW'(busy), CW'(0));
    checkOutput("reset rsp_val", CW'(rsp_val), CW'(0));
    checkOutput("reset mac ctl", CW'({mac_h2b_val, mac_we, mac_b2h_rdy, mac_c_re}), CW'(0));
    checkOutput("reset rsp_c", rsp_c, '0);
    checkOutput("reset err", CW'({err_sticky, rsp_err}), CW'(0));
    req_val = 2'b00;
    rstn = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 4; t++) applyStimulus(tbl[t]);

    // Requester 0 was left pending during the timeout response; it must still be served.
    j = '{0, 2, 0, 2, 0, 2'b00, 2'b00, 7, 1'b0, 116};
    applyStimulus(j);

    // Stray completion strobes while idle.
    noise_done  = 1'b1;
    mac_b2h_val = 1'b1;
    @(negedge clk);
    noise_done = 1'b0;
    @(negedge clk);
    checkOutput("ignore stray done", CW'({busy, rsp_val}), CW'(0));

    // Reset in the middle of WAIT_DONE.
    h2b_wait   = 0;
    done_delay = 40;
    req_a[0]   = gen_a(1);
    req_b[0]   = gen_b(1);
    req_val[0] = 1'b1;
    @(posedge clk);
    #1;
    req_val = 2'b00;
    repeat (6) @(negedge clk);
    checkOutput("busy before reset", CW'(busy), CW'(1));
    rstn = 1'b0;
    #1;
    checkOutput("midjob reset ctl",
                CW'({busy, rsp_val, req_rdy, mac_h2b_val, mac_we, mac_b2h_rdy, mac_c_re}), CW'(0));
    checkOutput("midjob reset rsp_c", rsp_c, '0);
    checkOutput("midjob reset err", CW'({err_sticky, rsp_err}), CW'(0));
    exp_sticky = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    quiet = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rsp_val != 2'b00 || busy) quiet++;
    end
    checkOutput("no rsp after reset", CW'(quiet), CW'(0));

    // Simultaneous requests straight after reset: 0 first, then 1.
    grant_log.delete();
    req_a[1]   = gen_a(1);
    req_b[1]   = gen_b(1);
    req_val    = 2'b11;
    #1;
    checkOutput("contention rdy", CW'(req_rdy), CW'(2'b01));
    j = '{0, 0, 0, 2, 0, 2'b00, 2'b00, 7, 1'b0, 56};
    applyStimulus(j);
    j = '{1, 1, 1, 1, 0, 2'b00, 2'b00, 7, 1'b0, 50};
    applyStimulus(j);
    checkOutput("contention count", CW'(grant_log.size()), CW'(2));
    checkOutput("contention first", CW'(grant_log.size() > 0 ? grant_log[0] : 9), CW'(0));
    checkOutput("contention second", CW'(grant_log.size() > 1 ? grant_log[1] : 9), CW'(1));

    // Requester 1 back to back while requester 0 waits: grants 1, 0, 1.
    grant_log.delete();
    j = '{1, 2, 0, 1, 0, 2'b01, 2'b10, 6, 1'b0, 116};
    applyStimulus(j);
    j = '{0, 1, 2, 2, 0, 2'b00, 2'b00, 9, 1'b0, 50};
    applyStimulus(j);
    j = '{1, 0, 0, 4, 3, 2'b00, 2'b00, 9, 1'b0, 56};
    applyStimulus(j);
    checkOutput("alternate count", CW'(grant_log.size()), CW'(3));
    checkOutput("alternate g0", CW'(grant_log.size() > 0 ? grant_log[0] : 9), CW'(1));
    checkOutput("alternate g1", CW'(grant_log.size() > 1 ? grant_log[1] : 9), CW'(0));
    checkOutput("alternate g2", CW'(grant_log.size() > 2 ? grant_log[2] : 9), CW'(1));

    checkOutput("req_rdy never 11", CW'(both_rdy), CW'(0));
    checkOutput("mac_a/b outside LOAD", CW'(leak), CW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
